// File: rtl/i2c_slave.sv
// I2C target endpoint: oversampled SCL/SDA, 7-bit address match,
// byte receive/transmit, open-drain SDA, never stretches SCL.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstscl,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] data_send_slave,
  input  logic       data_send_slave_enable,
  output logic [7:0] data_receive_slave,
  output logic       data_receive_slave_enable,
  output logic       busy,
  output logic       error_slave
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_M_ACK,
    S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_pend;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_mack;
  logic       r_sda_oe;
  logic [7:0] r_tx_hold;
  logic       r_tx_valid;
  logic [7:0] r_rx_data;
  logic       r_rx_en;
  logic       r_err;

  state_t     w_state_nxt;
  logic [2:0] w_cnt_nxt;
  logic       w_pend_nxt;
  logic [7:0] w_shift_nxt;
  logic       w_rw_nxt;
  logic       w_mack_nxt;
  logic       w_oe_nxt;
  logic [7:0] w_hold_nxt;
  logic       w_txv_nxt;
  logic [7:0] w_rx_nxt;
  logic       w_rx_en_nxt;
  logic       w_err_nxt;

  logic       w_scl_s;
  logic       w_sda_s;
  logic       w_rise;
  logic       w_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_cnt_st;
  logic       w_mid;
  logic [7:0] w_load_val;
  logic       w_load_err;

  assign sda = r_sda_oe ? 1'b0 : 1'bz;

  assign data_receive_slave        = r_rx_data;
  assign data_receive_slave_enable = r_rx_en;
  assign error_slave               = r_err;
  assign busy                      = (r_state != S_IDLE);

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];
  assign w_rise  = w_scl_s & ~r_scl_d;
  assign w_fall  = ~w_scl_s & r_scl_d;
  assign w_start = r_scl_d & w_scl_s & r_sda_d & ~w_sda_s;
  assign w_stop  = r_scl_d & w_scl_s & ~r_sda_d & w_sda_s;

  // A rise not yet followed by a fall may be the setup of START/STOP,
  // so it does not count as a completed bit.
  assign w_cnt_st = (r_state == S_ADDR) |
                    (r_state == S_RX) |
                    (r_state == S_TX);
  assign w_mid = w_cnt_st &
                 ~((r_cnt == 3'd0) |
                   ((r_cnt == 3'd1) & r_pend));

  // A strobe in the load cycle wins over the held byte.
  assign w_load_val = data_send_slave_enable ? data_send_slave :
                      r_tx_valid ? r_tx_hold : 8'hFF;
  assign w_load_err = ~data_send_slave_enable & ~r_tx_valid;

  // Input synchronizers and one-cycle history for edge detection
  always_ff @(posedge clk or negedge rstscl) begin
    if (!rstscl) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_shift_nxt = r_shift;
    w_rw_nxt    = r_rw;
    w_mack_nxt  = r_mack;
    w_oe_nxt    = r_sda_oe;
    w_hold_nxt  = r_tx_hold;
    w_txv_nxt   = r_tx_valid;
    w_rx_nxt    = r_rx_data;
    w_rx_en_nxt = 1'b0;
    w_err_nxt   = 1'b0;

    if (data_send_slave_enable) begin
      w_hold_nxt = data_send_slave;
      w_txv_nxt  = 1'b1;
    end

    if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_oe_nxt    = 1'b0;
      w_cnt_nxt   = 3'd0;
      w_pend_nxt  = 1'b0;
      w_mack_nxt  = 1'b0;
      w_err_nxt   = w_mid;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
      w_oe_nxt    = 1'b0;
      w_cnt_nxt   = 3'd0;
      w_pend_nxt  = 1'b0;
      w_mack_nxt  = 1'b0;
      w_err_nxt   = w_mid;
    end else begin
      if (w_rise) w_pend_nxt = 1'b1;
      if (w_fall) w_pend_nxt = 1'b0;
      unique case (r_state)
        S_IDLE: ;
        S_ADDR: begin
          if (w_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda_s};
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              if ((r_shift[6:0] == SLAVE_ADDR) &&
                  (r_shift[6:0] != 7'd0)) begin
                w_rw_nxt    = w_sda_s;
                w_state_nxt = S_ADDR_ACK;
              end else begin
                w_state_nxt = S_WAIT_STOP;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_fall) begin
            w_cnt_nxt = 3'd0;
            if (!r_sda_oe) begin
              w_oe_nxt = 1'b1;
            end else if (r_rw) begin
              w_shift_nxt = w_load_val;
              w_oe_nxt    = ~w_load_val[7];
              w_txv_nxt   = 1'b0;
              w_err_nxt   = w_load_err;
              w_state_nxt = S_TX;
            end else begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = S_RX;
            end
          end
        end
        S_RX: begin
          if (w_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda_s};
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_rx_nxt    = {r_shift[6:0], w_sda_s};
              w_rx_en_nxt = 1'b1;
              w_state_nxt = S_RX_ACK;
            end
          end
        end
        S_RX_ACK: begin
          if (w_fall) begin
            w_cnt_nxt = 3'd0;
            if (!r_sda_oe) begin
              w_oe_nxt = 1'b1;
            end else begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = S_RX;
            end
          end
        end
        S_TX: begin
          if (w_rise) begin
            w_cnt_nxt = r_cnt + 3'd1;
          end else if (w_fall) begin
            if (r_cnt == 3'd0) begin
              w_oe_nxt    = 1'b0;
              w_mack_nxt  = 1'b0;
              w_state_nxt = S_M_ACK;
            end else begin
              w_shift_nxt = {r_shift[6:0], 1'b0};
              w_oe_nxt    = ~r_shift[6];
            end
          end
        end
        S_M_ACK: begin
          if (w_rise) begin
            if (!w_sda_s) w_mack_nxt = 1'b1;
            else          w_state_nxt = S_WAIT_STOP;
          end else if (w_fall && r_mack) begin
            w_shift_nxt = w_load_val;
            w_oe_nxt    = ~w_load_val[7];
            w_txv_nxt   = 1'b0;
            w_err_nxt   = w_load_err;
            w_cnt_nxt   = 3'd0;
            w_mack_nxt  = 1'b0;
            w_state_nxt = S_TX;
          end
        end
        S_WAIT_STOP: ;
      endcase
    end
  end

  // State and datapath registers; reset releases SDA at once
  always_ff @(posedge clk or negedge rstscl) begin
    if (!rstscl) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_pend     <= 1'b0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_mack     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_tx_hold  <= 8'hFF;
      r_tx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_en    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_shift    <= w_shift_nxt;
      r_rw       <= w_rw_nxt;
      r_mack     <= w_mack_nxt;
      r_sda_oe   <= w_oe_nxt;
      r_tx_hold  <= w_hold_nxt;
      r_tx_valid <= w_txv_nxt;
      r_rx_data  <= w_rx_nxt;
      r_rx_en    <= w_rx_en_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bus-level master, table vectors,
// corner sequences and random transactions vs a byte-level model.
module tb_i2c_slave;

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    logic        stb;
    logic [7:0]  sv;
    int          nb;
    logic [23:0] d;
    logic        aack;
    logic [23:0] e;
    int          nen;
    int          nerr;
  } vec_t;

  logic       clk    = 1'b0;
  logic       rstscl = 1'b0;
  logic       scl    = 1'b1;
  logic       m_oe   = 1'b0;
  wire        sda;
  logic [7:0] dss    = 8'h00;
  logic       dss_en = 1'b0;
  logic [7:0] drs;
  logic       drs_en;
  logic       busy;
  logic       err;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk                       (clk),
    .rstscl                    (rstscl),
    .scl                       (scl),
    .sda                       (sda),
    .data_send_slave           (dss),
    .data_send_slave_enable    (dss_en),
    .data_receive_slave        (drs),
    .data_receive_slave_enable (drs_en),
    .busy                      (busy),
    .error_slave               (err)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int n_en = 0;
  int n_err = 0;
  logic [7:0] q_rx[$];

  // byte-level model of the tx holding register
  logic       mv = 1'b0;
  logic [7:0] mval = 8'hFF;

  always @(negedge clk) begin
    if (drs_en) begin
      n_en++;
      q_rx.push_back(drs);
    end
    if (err) n_err++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic qd();
    repeat (4) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic r);
    m_oe = ~b; qd();
    scl = 1'b1; qd();
    r = sda; qd();
    scl = 1'b0; qd();
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; qd();
    scl = 1'b1; qd();
    m_oe = 1'b1; qd();
    scl = 1'b0; qd();
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; qd();
    scl = 1'b1; qd();
    m_oe = 1'b0; qd();
    qd();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(~ack, r);
  endtask

  task automatic strobe(input logic [7:0] v);
    dss = v; dss_en = 1'b1;
    @(negedge clk);
    dss_en = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    logic ack;
    logic [7:0] b;
    int en0, er0, q0;
    if (v.stb) strobe(v.sv);
    en0 = n_en; er0 = n_err; q0 = q_rx.size();
    i2c_start();
    chk("busy_start", busy, 1);
    wr_byte({v.addr, v.rw}, ack);
    chk("addr_ack", ack, v.aack);
    for (int k = 0; k < v.nb; k++) begin
      if (v.rw && v.aack) begin
        rd_byte(k < v.nb - 1, b);
        chk("rd_byte", b, v.e[23-8*k -: 8]);
      end else begin
        wr_byte(v.d[23-8*k -: 8], ack);
        chk("wr_ack", ack, v.aack);
      end
    end
    i2c_stop(); qd();
    chk("busy_stop", busy, 0);
    chk("en_cnt", n_en - en0, v.nen);
    chk("err_cnt", n_err - er0, v.nerr);
    for (int k = 0; k < v.nen; k++)
      chk("rx_byte",
          (q0 + k < q_rx.size()) ? {24'd0, q_rx[q0+k]} : 32'h100,
          v.e[23-8*k -: 8]);
  endtask

  // Expected results come from byte-level rules: address match,
  // ACK per written byte, one held byte consumed per read byte.
  task automatic mk_rand(output vec_t v);
    v.addr = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h50;
    v.rw   = 1'($urandom);
    v.stb  = 1'($urandom);
    v.sv   = 8'($urandom);
    v.nb   = $urandom_range(1, 3);
    v.d    = 24'($urandom);
    v.aack = (v.addr == 7'h50);
    v.e    = '0;
    v.nen  = 0;
    v.nerr = 0;
    if (v.stb) begin
      mv = 1'b1;
      mval = v.sv;
    end
    if (v.aack && !v.rw) begin
      v.nen = v.nb;
      v.e = v.d;
    end
    if (v.aack && v.rw) begin
      for (int k = 0; k < v.nb; k++) begin
        if (mv) begin
          v.e[23-8*k -: 8] = mval;
          mv = 1'b0;
        end else begin
          v.e[23-8*k -: 8] = 8'hFF;
          v.nerr++;
        end
      end
    end
  endtask

  vec_t tbl[9];

  initial begin
    vec_t v;
    logic ack, r;
    int en0, er0;

    tbl[0] = '{7'h50, 1'b0, 1'b0, 8'h00, 1, 24'h3C0000,
               1'b1, 24'h3C0000, 1, 0};
    tbl[1] = '{7'h51, 1'b0, 1'b0, 8'h00, 1, 24'h770000,
               1'b0, 24'h000000, 0, 0};
    tbl[2] = '{7'h50, 1'b1, 1'b1, 8'h96, 1, 24'h000000,
               1'b1, 24'h960000, 0, 0};
    tbl[3] = '{7'h50, 1'b1, 1'b1, 8'hA5, 2, 24'h000000,
               1'b1, 24'hA5FF00, 0, 1};
    tbl[4] = '{7'h50, 1'b0, 1'b0, 8'h00, 3, 24'h00FF81,
               1'b1, 24'h00FF81, 3, 0};
    tbl[5] = '{7'h00, 1'b0, 1'b0, 8'h00, 1, 24'h120000,
               1'b0, 24'h000000, 0, 0};
    tbl[6] = '{7'h50, 1'b1, 1'b0, 8'h00, 1, 24'h000000,
               1'b1, 24'hFF0000, 0, 1};
    tbl[7] = '{7'h50, 1'b0, 1'b1, 8'h44, 1, 24'h010000,
               1'b1, 24'h010000, 1, 0};
    tbl[8] = '{7'h50, 1'b1, 1'b0, 8'h00, 1, 24'h000000,
               1'b1, 24'h440000, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx", drs, 0);
    chk("rst_en", drs_en, 0);
    chk("rst_err", err, 0);
    rstscl = 1'b1;
    qd();

    for (int i = 0; i < 9; i++) do_txn(tbl[i]);

    // repeated START at a byte boundary, then one mid-byte
    en0 = n_en; er0 = n_err;
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h11, ack);
    i2c_start();
    chk("rs_busy", busy, 1);
    wr_byte(8'hA0, ack);
    chk("rs_ack", ack, 1);
    bit_io(1'b1, r);
    bit_io(1'b0, r);
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h22, ack);
    i2c_stop(); qd();
    chk("rs_en", n_en - en0, 2);
    chk("rs_err", n_err - er0, 1);
    chk("rs_last", drs, 8'h22);

    // STOP after 4 bits of a data byte
    en0 = n_en; er0 = n_err;
    i2c_start();
    wr_byte(8'hA0, ack);
    bit_io(1'b1, r);
    bit_io(1'b0, r);
    bit_io(1'b1, r);
    bit_io(1'b1, r);
    i2c_stop(); qd();
    chk("ps_err", n_err - er0, 1);
    chk("ps_en", n_en - en0, 0);
    chk("ps_busy", busy, 0);

    // async reset while the slave drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_io(i == 7 || i == 5, r);
    m_oe = 1'b0;
    repeat (2) @(negedge clk);
    chk("ack_drv", sda, 0);
    rstscl = 1'b0;
    #1;
    chk("rst_rel", sda, 1);
    chk("rst_busy2", busy, 0);
    @(negedge clk);
    rstscl = 1'b1;
    scl = 1'b1;
    qd(); qd();
    v = '{7'h50, 1'b0, 1'b0, 8'h00, 1, 24'h5A0000,
          1'b1, 24'h5A0000, 1, 0};
    do_txn(v);

    mv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mk_rand(v);
      do_txn(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
